uart_rx_ctrl: RTL and testbench



---
 rtl/uart_rx_ctrl_if.sv | 34 +++
 rtl/uart_rx_ctrl.sv | 178 +++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if -- CPU register bus for the MiniUart receive controller.
//
// Signals:
//   addr   register select (0 DATA, 1 STATUS, 2 DIV, 3 CTRL)
//   rd     read strobe, one cycle; side effects (pop, overrun clear) at the edge
//   we     write strobe, one cycle
//   wdata  write data
//   rdata  read data, combinational from addr
//   irq    registered interrupt request
//
// Handshake: rd and we are single-cycle strobes with no back-pressure. The
// slave always accepts a strobe on the clock edge where it is high, and rdata
// is valid in that same cycle. rd and we may both be high; both take effect.
//
// Modports: master drives the bus (CPU or testbench), slave is the controller.

interface uart_rx_ctrl_if;
    logic [1:0]  addr;
    logic        rd;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (
        output addr, rd, we, wdata,
        input  rdata, irq
    );

    modport slave (
        input  addr, rd, we, wdata,
        output rdata, irq
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl -- receive-side controller for the MiniUart rx_unit.
//
// Paces rx_unit with an 8x-oversample enable derived from a programmable
// divisor, drains completed bytes from rx_unit into a small FIFO through the
// rs/over_read handshake, and exposes DATA/STATUS/DIV/CTRL registers plus an
// interrupt line on the CPU bus.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-low reset
//   en_rx      oversample enable to rx_unit, one-cycle pulse per tick
//   rx_data    rx_unit d_out
//   rx_rs      rx_unit receive status (byte available)
//   over_read  one-cycle pulse that clears rx_unit rs
//   bus        CPU register bus (slave side)
//   dbg_state  current drain FSM state, for observation only

module uart_rx_ctrl #(
    parameter logic [15:0] DIV_INIT   = 16'd1,
    parameter int          FIFO_DEPTH = 4,
    parameter int          CW         = 3
) (
    input  logic              clk,
    input  logic              rst,
    output logic              en_rx,
    input  logic [7:0]        rx_data,
    input  logic              rx_rs,
    output logic              over_read,
    uart_rx_ctrl_if.slave     bus,
    output logic [1:0]        dbg_state
);

    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CAPT = 2'd1,
        S_ACK  = 2'd2,
        S_WCLR = 2'd3
    } state_t;

    state_t          state, state_n;

    logic [15:0]     div;
    logic [15:0]     cnt;
    logic [15:0]     eff_div;
    logic            ie, en;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count, count_n;
    logic            overrun, overrun_n;
    logic            full, empty, empty_n;
    logic            push, pop, capt;
    logic            wr_div, wr_ctrl, rd_stat;
    logic            ie_n;
    logic [7:0]      stat;
    logic            unused_wdata;

    // ---------------- bus decode ----------------
    assign wr_div  = bus.we && (bus.addr == 2'd2);
    assign wr_ctrl = bus.we && (bus.addr == 2'd3);
    assign rd_stat = bus.rd && (bus.addr == 2'd1);
    assign unused_wdata = ^bus.wdata[31:16];

    // ---------------- tick generator ----------------
    // A divisor of 0 is treated as 1 so the counter compare never underflows.
    assign eff_div = (div == 16'd0) ? 16'd1 : div;
    assign en_rx   = en && (cnt == eff_div - 16'd1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            div <= DIV_INIT;
            ie  <= 1'b0;
            en  <= 1'b0;
            cnt <= 16'd0;
        end else begin
            if (wr_div)  div <= bus.wdata[15:0];
            if (wr_ctrl) begin
                ie <= bus.wdata[1];
                en <= bus.wdata[0];
            end
            // Any reconfiguration restarts the tick period from zero.
            if (wr_div || wr_ctrl || !en || en_rx) cnt <= 16'd0;
            else                                   cnt <= cnt + 16'd1;
        end
    end

    // ---------------- FIFO ----------------
    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign pop   = bus.rd && (bus.addr == 2'd0) && !empty;
    assign capt  = (state == S_CAPT);
    // A simultaneous pop frees a slot, so a full FIFO can still take the byte.
    assign push  = capt && (!full || pop);

    always_comb begin
        count_n = count;
        if (push && !pop)      count_n = count + CW'(1);
        else if (pop && !push) count_n = count - CW'(1);
    end

    // Overrun set wins over the STATUS read clear in the same cycle.
    always_comb begin
        overrun_n = overrun;
        if (capt && !push) overrun_n = 1'b1;
        else if (rd_stat)  overrun_n = 1'b0;
    end

    assign empty_n = (count_n == '0);
    assign ie_n    = wr_ctrl ? bus.wdata[1] : ie;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
            bus.irq <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count   <= count_n;
            overrun <= overrun_n;
            // irq reflects the state after this edge, not the old one.
            bus.irq <= ie_n && (!empty_n || overrun_n);
        end
    end

    // ---------------- drain FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n   = state;
        over_read = 1'b0;
        case (state)
            S_IDLE: if (rx_rs) state_n = S_CAPT;
            S_CAPT: state_n = S_ACK;
            S_ACK: begin
                over_read = 1'b1;
                state_n   = S_WCLR;
            end
            S_WCLR: if (!rx_rs) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign dbg_state = state;

    // ---------------- read mux ----------------
    // Count occupies the low CW bits of STATUS (CW is at most 3 here).
    always_comb begin
        stat         = 8'd0;
        stat[6]      = overrun;
        stat[5]      = full;
        stat[4]      = empty;
        stat[CW-1:0] = count;
    end

    always_comb begin
        bus.rdata = 32'd0;
        case (bus.addr)
            2'd0: bus.rdata = empty ? 32'd0 : {24'd0, mem[rd_ptr]};
            2'd1: bus.rdata = {24'd0, stat};
            2'd2: bus.rdata = {16'd0, div};
            2'd3: bus.rdata = {30'd0, ie, en};
            default: bus.rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl -- directed bench for uart_rx_ctrl with a byte scoreboard.

module tb_uart_rx_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       en_rx, over_read, rx_rs;
    logic [7:0] rx_data;
    logic [1:0] dbg_state;

    uart_rx_ctrl_if bus_if ();

    uart_rx_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .en_rx     (en_rx),
        .rx_data   (rx_data),
        .rx_rs     (rx_rs),
        .over_read (over_read),
        .bus       (bus_if),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int tests = 0;
    int fails = 0;
    int or_pulses = 0;

    always @(negedge clk) if (over_read) or_pulses++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_if.addr  = a;
        bus_if.wdata = d;
        bus_if.we    = 1'b1;
        @(negedge clk);
        bus_if.we    = 1'b0;
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        bus_if.addr = a;
        bus_if.rd   = 1'b1;
        #1 d = bus_if.rdata;
        @(negedge clk);
        bus_if.rd   = 1'b0;
    endtask

    task automatic rd_data(input string tag);
        logic [31:0] d;
        logic [31:0] e;
        e = exp_q.size() == 0 ? 32'd0 : {24'd0, exp_q.pop_front()};
        rd_reg(2'd0, d);
        check(tag, d, e);
    endtask

    task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] e);
        logic [31:0] d;
        rd_reg(a, d);
        check(tag, d, e);
    endtask

    // rx_unit model: raise rs with a byte, clear it when over_read is seen.
    task automatic send_byte(input logic [7:0] b, input bit accept);
        int base;
        int lat;
        base = or_pulses;
        lat  = 99;
        @(negedge clk);
        rx_data = b;
        rx_rs   = 1'b1;
        if (accept) exp_q.push_back(b);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (over_read) begin
                lat = i;
                break;
            end
        end
        rx_rs = 1'b0;
        check("or_latency", lat, 2);
        @(negedge clk);
        @(negedge clk);
        check("or_once", or_pulses - base, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        rx_rs        = 1'b0;
        rx_data      = 8'd0;
        bus_if.addr  = 2'd0;
        bus_if.rd    = 1'b0;
        bus_if.we    = 1'b0;
        bus_if.wdata = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_en_rx", en_rx, 0);
        check("rst_over_read", over_read, 0);
        check("rst_irq", bus_if.irq, 0);
        check("rst_state", dbg_state, 0);
        rst = 1'b1;
        rd_check("rst_div", 2'd2, 32'd1);
        rd_check("rst_ctrl", 2'd3, 32'd0);
        rd_check("rst_status", 2'd1, 32'h10);

        // Tick generator: DIV=4 then DIV=2.
        wr(2'd2, 32'd4);
        wr(2'd3, 32'd1);
        for (int i = 0; i < 12; i++) begin
            check("tick_div4", en_rx, (i % 4) == 3);
            @(negedge clk);
        end
        wr(2'd2, 32'd2);
        for (int i = 0; i < 8; i++) begin
            check("tick_div2", en_rx, (i % 2) == 1);
            @(negedge clk);
        end

        // Single byte.
        send_byte(8'hA5, 1'b1);
        rd_data("data_a5");
        rd_check("status_after_pop", 2'd1, 32'h10);

        // Overrun: five bytes, no reads.
        for (int i = 1; i <= 5; i++) send_byte(8'(i), i <= 4);
        rd_check("status_overrun", 2'd1, 32'h64);
        rd_check("status_cleared", 2'd1, 32'h24);
        for (int i = 0; i < 4; i++) rd_data("data_drain");
        rd_data("data_empty");
        rd_check("status_empty", 2'd1, 32'h10);

        // Full FIFO with CAPT coinciding with a DATA read.
        for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i), 1'b1);
        @(negedge clk);
        rx_data = 8'h15;
        rx_rs   = 1'b1;
        @(negedge clk);
        bus_if.addr = 2'd0;
        bus_if.rd   = 1'b1;
        #1 check("data_concurrent", bus_if.rdata, {24'd0, exp_q.pop_front()});
        exp_q.push_back(8'h15);
        @(negedge clk);
        bus_if.rd = 1'b0;
        check("or_concurrent", over_read, 1);
        rx_rs = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rd_check("status_full_no_ovr", 2'd1, 32'h24);
        for (int i = 0; i < 4; i++) rd_data("data_drain2");

        // Interrupt.
        wr(2'd3, 32'd3);
        check("irq_idle", bus_if.irq, 0);
        send_byte(8'h5A, 1'b1);
        check("irq_set", bus_if.irq, 1);
        rd_data("data_5a");
        check("irq_clear", bus_if.irq, 0);

        // Divisor 0: continuous enable.
        wr(2'd2, 32'd0);
        for (int i = 0; i < 5; i++) begin
            check("tick_div0", en_rx, 1);
            @(negedge clk);
        end

        // Reset during WCLR with rs still high.
        @(negedge clk);
        rx_data = 8'h77;
        rx_rs   = 1'b1;
        repeat (3) @(negedge clk);
        check("state_wclr", dbg_state, 3);
        rst = 1'b0;
        bus_if.addr = 2'd0;
        @(negedge clk);
        check("rrst_en_rx", en_rx, 0);
        check("rrst_over_read", over_read, 0);
        check("rrst_irq", bus_if.irq, 0);
        check("rrst_state", dbg_state, 0);
        #1 check("rrst_rdata", bus_if.rdata, 0);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        exp_q.push_back(8'h77);
        lat = 99;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (over_read) begin
                lat = i;
                break;
            end
        end
        rx_rs = 1'b0;
        check("redrain_latency", lat, 2);
        @(negedge clk);
        @(negedge clk);
        rd_data("data_redrain");
        rd_check("div_after_reset", 2'd2, 32'd1);

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
